julia_frame_sched: RTL

//  Frame-render sequencer for the Julia pipeline. Sweeps every pixel of an H_RES x V_RES frame and

---
 rtl/julia_pkg.sv | 28 ++
 rtl/julia_frame_sched_if.sv | 24 ++
 rtl/julia_coord_gen.sv | 63 ++++++
 rtl/julia_frame_sched.sv | 123 ++++++++++++
 4 files changed

// File: rtl/julia_pkg.sv
// Shared types and per-zoom constants for the Julia frame sequencer.
// Coordinates are Q16.16; each zoom level halves the viewed span.
package julia_pkg;

  localparam int ITER_MAX = 256;

  typedef logic [1:0] lvl_t;
  localparam lvl_t LVL_MAX = 2'd3;

  typedef enum logic [2:0] {
    S_INIT,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  // Left edge, top edge and per-pixel step for zoom levels x1, x2, x4, x8.
  localparam logic [31:0] REAL_MIN [4] = '{32'hfffc0000, 32'hfffe0000, 32'hffff0000, 32'hffff8000};
  localparam logic [31:0] IMAG_MAX [4] = '{32'h00024000, 32'h00012000, 32'h00009000, 32'h00004800};
  localparam logic [31:0] STEP     [4] = '{32'd409, 32'd204, 32'd102, 32'd51};

  // Saturated iteration counts map to the brightest palette entry.
  function automatic logic [3:0] quantise(input logic [8:0] iter);
    return (iter >= 9'(ITER_MAX)) ? 4'hF : iter[7:4];
  endfunction

endpackage

// File: rtl/julia_frame_sched_if.sv
// Core handshake and frame-BRAM write port of the Julia frame sequencer.
interface julia_frame_sched_if #(
  parameter int ADDR_W = 20
);
  logic              core_start;
  logic [31:0]       core_x;
  logic [31:0]       core_y;
  logic              c_change;
  logic              core_ready;
  logic [8:0]        core_iter;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [3:0]        wr_data;

  modport master (
    output core_start, core_x, core_y, c_change, wr_en, wr_addr, wr_data,
    input  core_ready, core_iter
  );

  modport slave (
    input  core_start, core_x, core_y, c_change, wr_en, wr_addr, wr_data,
    output core_ready, core_iter
  );
endinterface

// File: rtl/julia_coord_gen.sv
// Incremental pixel coordinate and BRAM address generator: no multipliers, no dividers.
// The zoom level is captured at load so a mid-frame zoom change cannot skew the step.
module julia_coord_gen
  import julia_pkg::*;
#(
  parameter int H_RES  = 1280,
  parameter int V_RES  = 720,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step_x,
  input  logic              next_line,
  input  lvl_t              lvl,
  output logic [31:0]       core_x,
  output logic [31:0]       core_y,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              end_of_line,
  output logic              last_px
);

  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);

  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  lvl_t          frame_lvl;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      wr_addr   <= '0;
      frame_lvl <= '0;
      core_x    <= '0;
      core_y    <= '0;
    end else if (load) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      wr_addr   <= '0;
      frame_lvl <= lvl;
      core_x    <= REAL_MIN[lvl];
      core_y    <= IMAG_MAX[lvl];
    end else if (step_x) begin
      x_cnt   <= x_cnt + XW'(1);
      wr_addr <= wr_addr + ADDR_W'(1);
      core_x  <= core_x + STEP[frame_lvl];
    end else if (next_line) begin
      // Imaginary axis counts down so the top line of the image is +imag.
      x_cnt   <= '0;
      y_cnt   <= y_cnt + YW'(1);
      wr_addr <= wr_addr + ADDR_W'(1);
      core_x  <= REAL_MIN[frame_lvl];
      core_y  <= core_y - STEP[frame_lvl];
    end
  end

  assign end_of_line = (x_cnt == XW'(H_RES - 1));
  assign last_px     = end_of_line && (y_cnt == YW'(V_RES - 1));

endmodule

// File: rtl/julia_frame_sched.sv
// Frame-render sequencer: sweeps the frame, hands each pixel to the Julia core, writes the
// quantised result to BRAM, and restarts the frame on any zoom or constant change.
module julia_frame_sched
  import julia_pkg::*;
#(
  parameter int H_RES  = 1280,
  parameter int V_RES  = 720,
  parameter int ADDR_W = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       zoom_in,
  input  logic                       zoom_out,
  input  logic                       c_req,
  julia_frame_sched_if.master        bus,
  output lvl_t                       zoom_level,
  output logic                       busy,
  output logic                       frame_done
);

  state_t     state, state_next;
  logic       rst_pend, c_pend, started;
  logic       load, step_x, next_line, take_result;
  logic       end_of_line, last_px;
  logic [3:0] wr_data;
  logic       zoom_inc, zoom_dec, restart_req;

  julia_coord_gen #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .ADDR_W(ADDR_W)
  ) u_coord (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .step_x     (step_x),
    .next_line  (next_line),
    .lvl        (zoom_level),
    .core_x     (bus.core_x),
    .core_y     (bus.core_y),
    .wr_addr    (bus.wr_addr),
    .end_of_line(end_of_line),
    .last_px    (last_px)
  );

  // Conflicting or saturated zoom requests neither change the level nor restart.
  assign zoom_inc    = zoom_in & ~zoom_out & (zoom_level != LVL_MAX);
  assign zoom_dec    = zoom_out & ~zoom_in & (zoom_level != '0);
  assign restart_req = zoom_inc | zoom_dec | c_req;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next  = state;
    load        = 1'b0;
    step_x      = 1'b0;
    next_line   = 1'b0;
    take_result = 1'b0;
    case (state)
      S_INIT: begin
        load       = 1'b1;
        state_next = S_ISSUE;
      end
      S_ISSUE: state_next = S_WAIT;
      S_WAIT: begin
        // The core is never aborted; a pending restart just discards its result.
        if (bus.core_ready) begin
          if (rst_pend) begin
            state_next = S_INIT;
          end else begin
            take_result = 1'b1;
            state_next  = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (rst_pend) begin
          state_next = S_INIT;
        end else if (last_px) begin
          state_next = S_DONE;
        end else if (end_of_line) begin
          next_line  = 1'b1;
          state_next = S_ISSUE;
        end else begin
          step_x     = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_DONE:  if (rst_pend) state_next = S_INIT;
      default: state_next = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_INIT;
      zoom_level <= '0;
      rst_pend   <= 1'b0;
      c_pend     <= 1'b0;
      started    <= 1'b0;
      frame_done <= 1'b0;
      wr_data    <= '0;
    end else begin
      state      <= state_next;
      started    <= 1'b1;
      frame_done <= (state == S_WRITE) && (state_next == S_DONE);
      if (take_result) wr_data <= quantise(bus.core_iter);
      if (zoom_inc)      zoom_level <= zoom_level + 2'd1;
      else if (zoom_dec) zoom_level <= zoom_level - 2'd1;
      // A request arriving in S_INIT wins over the clear, so it is never lost.
      if (restart_req)          rst_pend <= 1'b1;
      else if (state == S_INIT) rst_pend <= 1'b0;
      if (c_req)                c_pend <= 1'b1;
      else if (state == S_INIT) c_pend <= 1'b0;
    end
  end

  assign bus.core_start = (state == S_ISSUE);
  assign bus.wr_en      = (state == S_WRITE);
  assign bus.c_change   = (state == S_INIT) && c_pend;
  assign bus.wr_data    = wr_data;
  assign busy           = started && (state != S_DONE);

endmodule
